// File: rtl/usb_nrzi_receive.sv
// ---------------------------------------------------------------------------
// usb_nrzi_receive
//   Receive side of the NRZI line. Samples D+/D- once per clk, NRZI-decodes
//   (toggle = 1, hold = 0), checks the SYNC byte, assembles LSB-first data
//   bytes, detects SE0 end-of-packet and flags line/framing/babble errors.
//   All outputs are registered; strobes are one cycle wide and appear the
//   cycle after the line bit that caused them was sampled.
//
//   Optional feature: define USB_BITSTUFF_EN to enable bit-stuff removal
//   (a bit following six consecutive decoded zeros must be a 1 and is
//   dropped; a 0 there is an error). Without the macro every DIFF bit is
//   shifted and long zero runs are legal.
//
// Ports
//   clk          in   bit clock, one line bit per rising edge
//   rst          in   synchronous active-high reset
//   d_plus       in   line D+ (pre-synchronised)
//   d_minus      in   line D- (pre-synchronised)
//   rx_data      out  last completed data byte, held until the next one
//   rx_valid     out  strobe: rx_data updated
//   rx_sop       out  strobe: SYNC matched
//   rx_eop       out  strobe: valid EOP completed
//   rx_error     out  strobe: framing / stuff / babble error
//   rx_active    out  high while in SYNC, DATA or EOP
//   rx_byte_cnt  out  data bytes in the current packet, cleared on rx_sop
// ---------------------------------------------------------------------------
module usb_nrzi_receive #(
    parameter logic [7:0] SYNC_PATTERN = 8'h7F,
    parameter int         EOP_CYCLES   = 2,
    parameter int         MAX_BYTES    = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       d_plus,
    input  logic       d_minus,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_sop,
    output logic       rx_eop,
    output logic       rx_error,
    output logic       rx_active,
    output logic [6:0] rx_byte_cnt
);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] SYNC = 3'd1;
    localparam logic [2:0] DATA = 3'd2;
    localparam logic [2:0] EOP  = 3'd3;
    localparam logic [2:0] ERR  = 3'd4;

    localparam logic [3:0] EOP_MIN = 4'(EOP_CYCLES);
    localparam logic [6:0] MAX_CNT = 7'(MAX_BYTES);

    logic [2:0] state, state_nxt;
    logic [7:0] shreg, shreg_nxt;
    logic [2:0] bit_cnt, bit_cnt_nxt;
    logic [3:0] se0_cnt, se0_cnt_nxt;
    logic [7:0] data_nxt;
    logic [6:0] cnt_nxt;
    logic       sop_nxt, valid_nxt, eop_nxt, err_nxt;
    logic       prev_dp;

    logic       line_diff, line_se0, line_idle, dbit;
    logic [7:0] shifted;
    logic       stuff_skip, stuff_err;

    assign line_diff = d_plus ^ d_minus;
    assign line_se0  = ~d_plus & ~d_minus;
    assign line_idle = d_plus & d_minus;
    assign dbit      = d_plus ^ prev_dp;
    // LSB arrives first, so new bits enter at the top and walk down.
    assign shifted   = {dbit, shreg[7:1]};

`ifdef USB_BITSTUFF_EN
    logic [2:0] zero_cnt;

    assign stuff_skip = (zero_cnt == 3'd6) && dbit;
    assign stuff_err  = (zero_cnt == 3'd6) && !dbit;

    // Held at zero while idle, so the run always starts clean in SYNC.
    always_ff @(posedge clk) begin
        if (rst || state == IDLE)
            zero_cnt <= 3'd0;
        else if ((state == SYNC || state == DATA) && line_diff && !stuff_err)
            zero_cnt <= dbit ? 3'd0 : zero_cnt + 3'd1;
    end
`else
    assign stuff_skip = 1'b0;
    assign stuff_err  = 1'b0;
`endif

    always_comb begin
        state_nxt   = state;
        shreg_nxt   = shreg;
        bit_cnt_nxt = bit_cnt;
        se0_cnt_nxt = se0_cnt;
        data_nxt    = rx_data;
        cnt_nxt     = rx_byte_cnt;
        sop_nxt     = 1'b0;
        valid_nxt   = 1'b0;
        eop_nxt     = 1'b0;
        err_nxt     = 1'b0;
        case (state)
            IDLE: begin
                if (line_diff) begin
                    shreg_nxt   = shifted;
                    bit_cnt_nxt = 3'd1;
                    state_nxt   = SYNC;
                end
            end
            SYNC, DATA: begin
                if (line_diff) begin
                    if (stuff_err) begin
                        err_nxt   = 1'b1;
                        state_nxt = ERR;
                    end else if (!stuff_skip) begin
                        shreg_nxt = shifted;
                        if (bit_cnt == 3'd7) begin
                            bit_cnt_nxt = 3'd0;
                            if (state == SYNC) begin
                                if (shifted == SYNC_PATTERN) begin
                                    sop_nxt   = 1'b1;
                                    cnt_nxt   = 7'd0;
                                    state_nxt = DATA;
                                end else begin
                                    err_nxt   = 1'b1;
                                    state_nxt = ERR;
                                end
                            end else if (rx_byte_cnt == MAX_CNT) begin
                                // Babble: one byte more than allowed.
                                err_nxt   = 1'b1;
                                state_nxt = ERR;
                            end else begin
                                data_nxt  = shifted;
                                valid_nxt = 1'b1;
                                cnt_nxt   = rx_byte_cnt + 7'd1;
                            end
                        end else begin
                            bit_cnt_nxt = bit_cnt + 3'd1;
                        end
                    end
                end else if (state == DATA && line_se0 && bit_cnt == 3'd0) begin
                    se0_cnt_nxt = 4'd1;
                    state_nxt   = EOP;
                end else begin
                    err_nxt   = 1'b1;
                    state_nxt = ERR;
                end
            end
            EOP: begin
                if (line_se0) begin
                    if (se0_cnt != 4'hF)
                        se0_cnt_nxt = se0_cnt + 4'd1;
                end else if (line_idle) begin
                    if (se0_cnt >= EOP_MIN)
                        eop_nxt = 1'b1;
                    else
                        err_nxt = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    err_nxt   = 1'b1;
                    state_nxt = ERR;
                end
            end
            ERR: begin
                if (line_idle)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            shreg       <= 8'd0;
            bit_cnt     <= 3'd0;
            se0_cnt     <= 4'd0;
            prev_dp     <= 1'b1;
            rx_data     <= 8'd0;
            rx_byte_cnt <= 7'd0;
            rx_sop      <= 1'b0;
            rx_valid    <= 1'b0;
            rx_eop      <= 1'b0;
            rx_error    <= 1'b0;
            rx_active   <= 1'b0;
        end else begin
            state       <= state_nxt;
            shreg       <= shreg_nxt;
            bit_cnt     <= bit_cnt_nxt;
            se0_cnt     <= se0_cnt_nxt;
            prev_dp     <= d_plus;
            rx_data     <= data_nxt;
            rx_byte_cnt <= cnt_nxt;
            rx_sop      <= sop_nxt;
            rx_valid    <= valid_nxt;
            rx_eop      <= eop_nxt;
            rx_error    <= err_nxt;
            rx_active   <= (state_nxt == SYNC) || (state_nxt == DATA) || (state_nxt == EOP);
        end
    end

endmodule

// File: tb/tb_usb_nrzi_receive.sv
// ---------------------------------------------------------------------------
// tb_usb_nrzi_receive
//   Directed bench for usb_nrzi_receive. A small NRZI line driver (toggle =
//   1, hold = 0) feeds hand-chosen packets; each test task compares strobes,
//   data and counters against hand-computed values. Expectations for the
//   long-zero-run test follow USB_BITSTUFF_EN.
// ---------------------------------------------------------------------------
module tb_usb_nrzi_receive;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       d_plus = 1'b1;
    logic       d_minus = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid, rx_sop, rx_eop, rx_error, rx_active;
    logic [6:0] rx_byte_cnt;

    usb_nrzi_receive dut (
        .clk(clk), .rst(rst), .d_plus(d_plus), .d_minus(d_minus),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_sop(rx_sop),
        .rx_eop(rx_eop), .rx_error(rx_error), .rx_active(rx_active),
        .rx_byte_cnt(rx_byte_cnt)
    );

    always #5 clk = ~clk;

    int         n_cmp = 0;
    int         n_bad = 0;
    int         n_sop, n_valid, n_eop, n_err, n_multi;
    logic [7:0] last_data;
    logic       lvl = 1'b1;

    task automatic clear_tally();
        n_sop = 0; n_valid = 0; n_eop = 0; n_err = 0; n_multi = 0;
        last_data = 8'd0;
    endtask

    // Drive one line state for one clk, then sample just after the edge.
    task automatic line(input logic dp, input logic dm);
        d_plus  = dp;
        d_minus = dm;
        @(posedge clk);
        #1;
        if (rx_sop) n_sop++;
        if (rx_valid) begin n_valid++; last_data = rx_data; end
        if (rx_eop) n_eop++;
        if (rx_error) n_err++;
        if ({1'b0, rx_sop} + rx_valid + rx_eop + rx_error > 2'd1) n_multi++;
    endtask

    task automatic nrzi_bit(input logic b);
        if (b) lvl = ~lvl;
        line(lvl, ~lvl);
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 0; i < 8; i++) nrzi_bit(v[i]);
    endtask

    task automatic send_idle(input int n);
        lvl = 1'b1;
        for (int i = 0; i < n; i++) line(1'b1, 1'b1);
    endtask

    task automatic send_se0(input int n);
        lvl = 1'b0;
        for (int i = 0; i < n; i++) line(1'b0, 1'b0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        line(1'b1, 1'b1);
        line(1'b1, 1'b1);
        n_cmp++; if (rx_data !== 8'h00) begin n_bad++; $display("FAIL reset_data: got %h expected 00", rx_data); end
        n_cmp++; if ({rx_sop, rx_valid, rx_eop, rx_error} !== 4'b0000) begin n_bad++; $display("FAIL reset_strobes: got %b expected 0000", {rx_sop, rx_valid, rx_eop, rx_error}); end
        n_cmp++; if (rx_active !== 1'b0) begin n_bad++; $display("FAIL reset_active: got %b expected 0", rx_active); end
        n_cmp++; if (rx_byte_cnt !== 7'd0) begin n_bad++; $display("FAIL reset_cnt: got %0d expected 0", rx_byte_cnt); end
        rst = 1'b0;
        clear_tally();
        send_idle(20);
        n_cmp++; if (n_sop + n_valid + n_eop + n_err !== 0) begin n_bad++; $display("FAIL idle_strobes: got %0d expected 0", n_sop + n_valid + n_eop + n_err); end
        n_cmp++; if (rx_active !== 1'b0) begin n_bad++; $display("FAIL idle_active: got %b expected 0", rx_active); end
    endtask

    task automatic test_good_packet();
        clear_tally();
        send_byte(8'h7F);
        n_cmp++; if (rx_sop !== 1'b1) begin n_bad++; $display("FAIL good_sop: got %b expected 1", rx_sop); end
        n_cmp++; if (rx_active !== 1'b1) begin n_bad++; $display("FAIL good_active: got %b expected 1", rx_active); end
        send_byte(8'hA5);
        n_cmp++; if (rx_valid !== 1'b1 || rx_data !== 8'hA5) begin n_bad++; $display("FAIL good_byte1: got %b/%h expected 1/a5", rx_valid, rx_data); end
        n_cmp++; if (rx_byte_cnt !== 7'd1) begin n_bad++; $display("FAIL good_cnt1: got %0d expected 1", rx_byte_cnt); end
        send_byte(8'h3C);
        n_cmp++; if (rx_valid !== 1'b1 || rx_data !== 8'h3C) begin n_bad++; $display("FAIL good_byte2: got %b/%h expected 1/3c", rx_valid, rx_data); end
        n_cmp++; if (rx_byte_cnt !== 7'd2) begin n_bad++; $display("FAIL good_cnt2: got %0d expected 2", rx_byte_cnt); end
        send_se0(2);
        n_cmp++; if (rx_active !== 1'b1 || rx_eop !== 1'b0) begin n_bad++; $display("FAIL good_in_eop: got active=%b eop=%b expected 1/0", rx_active, rx_eop); end
        send_idle(1);
        n_cmp++; if (rx_eop !== 1'b1) begin n_bad++; $display("FAIL good_eop: got %b expected 1", rx_eop); end
        n_cmp++; if (rx_active !== 1'b0) begin n_bad++; $display("FAIL good_active_after: got %b expected 0", rx_active); end
        send_idle(2);
        n_cmp++; if ({n_sop, n_valid, n_eop, n_err} !== {32'd1, 32'd2, 32'd1, 32'd0}) begin n_bad++; $display("FAIL good_totals: got sop=%0d valid=%0d eop=%0d err=%0d expected 1/2/1/0", n_sop, n_valid, n_eop, n_err); end
    endtask

    task automatic test_zero_length();
        clear_tally();
        send_byte(8'h7F);
        send_se0(2);
        send_idle(1);
        n_cmp++; if (rx_eop !== 1'b1) begin n_bad++; $display("FAIL zlp_eop: got %b expected 1", rx_eop); end
        n_cmp++; if (rx_byte_cnt !== 7'd0) begin n_bad++; $display("FAIL zlp_cnt: got %0d expected 0", rx_byte_cnt); end
        send_idle(2);
        n_cmp++; if ({n_sop, n_valid, n_err} !== {32'd1, 32'd0, 32'd0}) begin n_bad++; $display("FAIL zlp_totals: got sop=%0d valid=%0d err=%0d expected 1/0/0", n_sop, n_valid, n_err); end
    endtask

    task automatic test_bad_sync();
        clear_tally();
        send_byte(8'h7E);
        n_cmp++; if (rx_error !== 1'b1 || rx_sop !== 1'b0) begin n_bad++; $display("FAIL badsync_err: got err=%b sop=%b expected 1/0", rx_error, rx_sop); end
        n_cmp++; if (rx_active !== 1'b0) begin n_bad++; $display("FAIL badsync_active: got %b expected 0", rx_active); end
        send_idle(1);
        n_cmp++; if (rx_error !== 1'b0) begin n_bad++; $display("FAIL badsync_err_width: got %b expected 0", rx_error); end
        send_byte(8'h7F);
        send_byte(8'h5A);
        send_se0(2);
        send_idle(1);
        n_cmp++; if (rx_eop !== 1'b1) begin n_bad++; $display("FAIL badsync_recover_eop: got %b expected 1", rx_eop); end
        send_idle(2);
        n_cmp++; if ({n_sop, n_valid, n_eop, n_err} !== {32'd1, 32'd1, 32'd1, 32'd1}) begin n_bad++; $display("FAIL badsync_totals: got sop=%0d valid=%0d eop=%0d err=%0d expected 1/1/1/1", n_sop, n_valid, n_eop, n_err); end
        n_cmp++; if (last_data !== 8'h5A) begin n_bad++; $display("FAIL badsync_recover_data: got %h expected 5a", last_data); end
    endtask

    task automatic test_early_se0();
        clear_tally();
        send_byte(8'h7F);
        nrzi_bit(1'b1); nrzi_bit(1'b0); nrzi_bit(1'b1);
        send_se0(1);
        n_cmp++; if (rx_error !== 1'b1) begin n_bad++; $display("FAIL midbyte_se0_err: got %b expected 1", rx_error); end
        send_idle(2);
        send_byte(8'h7F);
        send_se0(1);
        send_idle(1);
        n_cmp++; if (rx_error !== 1'b1 || rx_eop !== 1'b0) begin n_bad++; $display("FAIL short_eop_err: got err=%b eop=%b expected 1/0", rx_error, rx_eop); end
        send_idle(2);
        n_cmp++; if ({n_valid, n_eop, n_err} !== {32'd0, 32'd0, 32'd2}) begin n_bad++; $display("FAIL early_totals: got valid=%0d eop=%0d err=%0d expected 0/0/2", n_valid, n_eop, n_err); end
    endtask

    task automatic test_long_zeros();
        clear_tally();
        send_byte(8'h7F);
        send_byte(8'hFF);
`ifdef USB_BITSTUFF_EN
        // Six zeros, stuffed one, two zeros -> 8'h00.
        for (int i = 0; i < 6; i++) nrzi_bit(1'b0);
        nrzi_bit(1'b1);
        nrzi_bit(1'b0); nrzi_bit(1'b0);
        n_cmp++; if (rx_valid !== 1'b1 || rx_data !== 8'h00) begin n_bad++; $display("FAIL stuff_byte: got %b/%h expected 1/00", rx_valid, rx_data); end
        send_se0(2);
        send_idle(2);
        n_cmp++; if ({n_valid, n_eop, n_err} !== {32'd2, 32'd1, 32'd0}) begin n_bad++; $display("FAIL stuff_totals: got valid=%0d eop=%0d err=%0d expected 2/1/0", n_valid, n_eop, n_err); end
        clear_tally();
        send_byte(8'h7F);
        send_byte(8'hFF);
        for (int i = 0; i < 7; i++) nrzi_bit(1'b0);
        n_cmp++; if (rx_error !== 1'b1) begin n_bad++; $display("FAIL stuff_violation: got %b expected 1", rx_error); end
        send_idle(2);
        n_cmp++; if ({n_valid, n_err} !== {32'd1, 32'd1}) begin n_bad++; $display("FAIL stuff_viol_totals: got valid=%0d err=%0d expected 1/1", n_valid, n_err); end
`else
        for (int i = 0; i < 8; i++) nrzi_bit(1'b0);
        n_cmp++; if (rx_valid !== 1'b1 || rx_data !== 8'h00) begin n_bad++; $display("FAIL zeros_byte: got %b/%h expected 1/00", rx_valid, rx_data); end
        send_se0(2);
        send_idle(2);
        n_cmp++; if ({n_valid, n_eop, n_err} !== {32'd2, 32'd1, 32'd0}) begin n_bad++; $display("FAIL zeros_totals: got valid=%0d eop=%0d err=%0d expected 2/1/0", n_valid, n_eop, n_err); end
`endif
    endtask

    task automatic test_reset_mid_and_babble();
        logic [7:0] v;
        clear_tally();
        send_byte(8'h7F);
        send_byte(8'hA5);
        nrzi_bit(1'b0); nrzi_bit(1'b0); nrzi_bit(1'b1); nrzi_bit(1'b1);
        rst = 1'b1;
        line(1'b1, 1'b1);
        n_cmp++; if (rx_data !== 8'h00 || rx_byte_cnt !== 7'd0) begin n_bad++; $display("FAIL midrst_clear: got data=%h cnt=%0d expected 00/0", rx_data, rx_byte_cnt); end
        n_cmp++; if ({rx_sop, rx_valid, rx_eop, rx_error, rx_active} !== 5'b00000) begin n_bad++; $display("FAIL midrst_outputs: got %b expected 00000", {rx_sop, rx_valid, rx_eop, rx_error, rx_active}); end
        rst = 1'b0;
        send_idle(2);
        n_cmp++; if ({n_valid, n_err} !== {32'd1, 32'd0}) begin n_bad++; $display("FAIL midrst_totals: got valid=%0d err=%0d expected 1/0", n_valid, n_err); end
        // 65 data bytes; bits 0 and 4 are always 1 so no zero run exceeds 3.
        clear_tally();
        send_byte(8'h7F);
        for (int i = 0; i < 65; i++) begin
            v = {i[2:0], 1'b1, i[5:3], 1'b1};
            send_byte(v);
        end
        n_cmp++; if (rx_error !== 1'b1 || rx_valid !== 1'b0) begin n_bad++; $display("FAIL babble_err: got err=%b valid=%b expected 1/0", rx_error, rx_valid); end
        send_se0(2);
        send_idle(2);
        n_cmp++; if ({n_valid, n_err, n_eop} !== {32'd64, 32'd1, 32'd0}) begin n_bad++; $display("FAIL babble_totals: got valid=%0d err=%0d eop=%0d expected 64/1/0", n_valid, n_err, n_eop); end
        n_cmp++; if (rx_byte_cnt !== 7'd64) begin n_bad++; $display("FAIL babble_cnt: got %0d expected 64", rx_byte_cnt); end
        // Byte index 63 encodes to 8'hFF.
        n_cmp++; if (last_data !== 8'hFF) begin n_bad++; $display("FAIL babble_last: got %h expected ff", last_data); end
        n_cmp++; if (n_multi !== 0) begin n_bad++; $display("FAIL one_hot: got %0d cycles with several strobes expected 0", n_multi); end
    endtask

    initial begin
        clear_tally();
        test_reset();
        test_good_packet();
        test_zero_length();
        test_bad_sync();
        test_early_se0();
        test_long_zeros();
        test_reset_mid_and_babble();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
